pipe_stall_ctrl: RTL and testbench

Central stall/flush sequencer for the five-stage MIPS pipeline. Collects hold requests from fetch, decode, the multi-cycle divider and the data-bus access in MEM. Drives per-register stall lines, the MEM/WB bubble line (`mem_stop_wb`) and a one-cycle global flush with PC redirect on exceptions. An exception that arrives while a data-bus transaction is outstanding is deferred until the transaction completes.

---
 rtl/pipe_stall_ctrl_pkg.sv | 46 ++++
 rtl/pipe_stall_ctrl_div_hold_timer.sv | 44 ++++
 rtl/pipe_stall_ctrl.sv | 187 ++++++++++++++++++
 tb/tb_pipe_stall_ctrl.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_stall_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// pipe_stall_ctrl_pkg
// Shared definitions for the pipeline stall/flush sequencer:
//   - sequencer state encoding
//   - stall bus width and the canonical stall patterns
//   - divider countdown width
//   - helper that resolves the low-priority (non-memory) stall sources
// -----------------------------------------------------------------------------
package pipe_stall_ctrl_pkg;

  // Sequencer states.
  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_DMEM_WAIT = 2'd1,
    ST_FLUSH     = 2'd2
  } state_t;

  // Stall bus: [0] PC, [1] IF/ID, [2] ID/EX, [3] EX/MEM.
  localparam int STALL_BUS = 4;
  typedef logic [STALL_BUS-1:0] stall_t;

  // Each pattern freezes the requesting stage and everything upstream of it;
  // the first non-stalled register downstream takes a bubble.
  localparam stall_t STALL_NONE = 4'b0000;
  localparam stall_t STALL_MEM  = 4'b1111;
  localparam stall_t STALL_EX   = 4'b0111;
  localparam stall_t STALL_ID   = 4'b0011;
  localparam stall_t STALL_IF   = 4'b0001;

  // Divider countdown width; covers DIV_CYCLES up to 63.
  localparam int DIV_CNT_W = 6;

  // Resolve the stall sources that sit below the data-bus/exception term.
  // The deepest stage that asks for a hold wins.
  function automatic stall_t low_prio_stall(input logic div_busy,
                                            input logic id_req,
                                            input logic fetch_req);
    stall_t s;
    if (div_busy)       s = STALL_EX;
    else if (id_req)    s = STALL_ID;
    else if (fetch_req) s = STALL_IF;
    else                s = STALL_NONE;
    return s;
  endfunction

endpackage

// File: rtl/pipe_stall_ctrl_div_hold_timer.sv
// -----------------------------------------------------------------------------
// div_hold_timer
// Countdown that keeps the EX stage frozen while the multi-cycle divider runs.
//   clk      : clock, rising edge
//   rst      : asynchronous active-high reset
//   i_start  : divide issued this cycle (pulse); ignored while already busy
//   i_clear  : abandon the running divide (pipeline flush)
//   o_busy   : countdown active
// A start at cycle t makes o_busy high for cycles t+1 .. t+DIV_CYCLES.
// -----------------------------------------------------------------------------
module div_hold_timer
  import pipe_stall_ctrl_pkg::*;
#(
  parameter int DIV_CYCLES = 32  // legal range 1..63
) (
  input  logic clk,
  input  logic rst,
  input  logic i_start,
  input  logic i_clear,
  output logic o_busy
);

  localparam logic [DIV_CNT_W-1:0] LOAD_VAL = DIV_CYCLES[DIV_CNT_W-1:0];

  logic [DIV_CNT_W-1:0] r_cnt;

  // NOTE: sequential state uses non-blocking assignments and the reset sits in
  // the sensitivity list, so reset takes effect without waiting for a clock.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_clear) begin
      r_cnt <= '0;
    end else if (r_cnt != '0) begin
      // Counts through stalls as well; a new start while busy is dropped.
      r_cnt <= r_cnt - 1'b1;
    end else if (i_start) begin
      r_cnt <= LOAD_VAL;
    end
  end

  assign o_busy = (r_cnt != '0);

endmodule

// File: rtl/pipe_stall_ctrl.sv
// -----------------------------------------------------------------------------
// pipe_stall_ctrl
// Central stall/flush sequencer for the five-stage pipeline.
//
// Inputs
//   cpu_clk_50M    : clock, rising edge
//   cpu_rst        : asynchronous active-high reset
//   if_stall_req   : instruction fetch not ready
//   id_stall_req   : load-use hazard in ID
//   div_start      : EX issues a divide (pulse)
//   mem_data_req   : instruction in MEM needs the data bus
//   mem_data_ok    : data-bus response (pulse)
//   exc_req        : exception / eret detected in MEM
//   exc_pc         : handler or EPC target, valid with exc_req
// Outputs
//   stall          : hold for [0] PC, [1] IF/ID, [2] ID/EX, [3] EX/MEM
//   mem_stop_wb    : MEM/WB bubble
//   flush          : clears every pipeline register (one cycle)
//   redirect_valid : PC load strobe
//   redirect_pc    : new PC (0 outside the flush cycle)
//   div_busy       : divide countdown active
//
// Stall responses are combinational. An exception seen while a data access is
// outstanding is parked (first one wins) and flushed in the cycle after the
// access completes.
// -----------------------------------------------------------------------------
module pipe_stall_ctrl
  import pipe_stall_ctrl_pkg::*;
#(
  parameter int DIV_CYCLES = 32,  // legal range 1..63
  parameter int PC_W       = 32
) (
  input  logic            cpu_clk_50M,
  input  logic            cpu_rst,
  input  logic            if_stall_req,
  input  logic            id_stall_req,
  input  logic            div_start,
  input  logic            mem_data_req,
  input  logic            mem_data_ok,
  input  logic            exc_req,
  input  logic [PC_W-1:0] exc_pc,
  output stall_t          stall,
  output logic            mem_stop_wb,
  output logic            flush,
  output logic            redirect_valid,
  output logic [PC_W-1:0] redirect_pc,
  output logic            div_busy
);

  state_t          r_state;
  state_t          w_state_nxt;
  logic            r_exc_pend;
  logic            w_exc_pend_nxt;
  logic [PC_W-1:0] r_exc_pc_q;
  logic [PC_W-1:0] w_exc_pc_nxt;
  logic            w_div_busy;
  logic            w_div_clear;

  // ---------------------------------------------------------------------------
  // Divider hold timer; a flush abandons any divide in flight.
  // ---------------------------------------------------------------------------
  assign w_div_clear = (r_state == ST_FLUSH);

  div_hold_timer #(
    .DIV_CYCLES (DIV_CYCLES)
  ) u_div_hold_timer (
    .clk     (cpu_clk_50M),
    .rst     (cpu_rst),
    .i_start (div_start),
    .i_clear (w_div_clear),
    .o_busy  (w_div_busy)
  );

  assign div_busy = w_div_busy;

  // ---------------------------------------------------------------------------
  // State register (with pending-exception bookkeeping).
  // ---------------------------------------------------------------------------
  always_ff @(posedge cpu_clk_50M or posedge cpu_rst) begin
    if (cpu_rst) begin
      r_state    <= ST_IDLE;
      r_exc_pend <= 1'b0;
      r_exc_pc_q <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_exc_pend <= w_exc_pend_nxt;
      r_exc_pc_q <= w_exc_pc_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic.
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path through
    // the case can leave it unassigned and infer a latch.
    w_state_nxt    = r_state;
    w_exc_pend_nxt = r_exc_pend;
    w_exc_pc_nxt   = r_exc_pc_q;

    case (r_state)
      ST_IDLE: begin
        if (exc_req) begin
          w_exc_pc_nxt = exc_pc;
          if (!mem_data_req || mem_data_ok) begin
            w_state_nxt = ST_FLUSH;
          end else begin
            // Access still in flight: park the exception until it returns.
            w_state_nxt    = ST_DMEM_WAIT;
            w_exc_pend_nxt = 1'b1;
          end
        end else if (mem_data_req && !mem_data_ok) begin
          w_state_nxt = ST_DMEM_WAIT;
        end
      end

      ST_DMEM_WAIT: begin
        // Only the first exception is kept; later ones are dropped.
        if (exc_req && !r_exc_pend) begin
          w_exc_pend_nxt = 1'b1;
          w_exc_pc_nxt   = exc_pc;
        end
        // An exception arriving together with the response is honoured too,
        // otherwise it would be stranded in IDLE with no path to a flush.
        if (mem_data_ok) begin
          w_state_nxt = (r_exc_pend || exc_req) ? ST_FLUSH : ST_IDLE;
        end
      end

      ST_FLUSH: begin
        w_exc_pend_nxt = 1'b0;
        w_state_nxt    = ST_IDLE;
      end

      default: begin
        w_state_nxt    = ST_IDLE;
        w_exc_pend_nxt = 1'b0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output logic. Everything is forced quiet while reset is held so stage
  // owners never see a stall or flush from a half-reset controller.
  // ---------------------------------------------------------------------------
  always_comb begin
    stall          = STALL_NONE;
    mem_stop_wb    = 1'b0;
    flush          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;

    if (!cpu_rst) begin
      case (r_state)
        ST_IDLE: begin
          if (exc_req || (mem_data_req && !mem_data_ok)) begin
            stall       = STALL_MEM;
            mem_stop_wb = 1'b1;
          end else begin
            stall = low_prio_stall(w_div_busy, id_stall_req, if_stall_req);
          end
        end

        ST_DMEM_WAIT: begin
          // mem_data_req is not looked at: the access is already outstanding.
          if (exc_req || !mem_data_ok) begin
            stall       = STALL_MEM;
            mem_stop_wb = 1'b1;
          end else begin
            stall = low_prio_stall(w_div_busy, id_stall_req, if_stall_req);
          end
        end

        ST_FLUSH: begin
          flush          = 1'b1;
          redirect_valid = 1'b1;
          redirect_pc    = r_exc_pc_q;
        end

        default: begin
          stall = STALL_NONE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pipe_stall_ctrl
// Directed scenarios followed by randomized traffic, all compared against a
// behavioural model of the sequencer built from the stall/flush rules.
// -----------------------------------------------------------------------------
module tb_pipe_stall_ctrl;

  localparam int DIV = 4;
  localparam int PW  = 32;

  logic          clk;
  logic          cpu_rst;
  logic          if_stall_req;
  logic          id_stall_req;
  logic          div_start;
  logic          mem_data_req;
  logic          mem_data_ok;
  logic          exc_req;
  logic [PW-1:0] exc_pc;
  logic [3:0]    stall;
  logic          mem_stop_wb;
  logic          flush;
  logic          redirect_valid;
  logic [PW-1:0] redirect_pc;
  logic          div_busy;

  pipe_stall_ctrl #(
    .DIV_CYCLES (DIV),
    .PC_W       (PW)
  ) dut (
    .cpu_clk_50M    (clk),
    .cpu_rst        (cpu_rst),
    .if_stall_req   (if_stall_req),
    .id_stall_req   (id_stall_req),
    .div_start      (div_start),
    .mem_data_req   (mem_data_req),
    .mem_data_ok    (mem_data_ok),
    .exc_req        (exc_req),
    .exc_pc         (exc_pc),
    .stall          (stall),
    .mem_stop_wb    (mem_stop_wb),
    .flush          (flush),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .div_busy       (div_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: "a data access is outstanding", "a flush happens this
  // cycle", "an exception is parked", and the remaining divide cycles.
  // ---------------------------------------------------------------------------
  bit          m_wait;
  bit          m_flush;
  bit          m_pend;
  logic [PW-1:0] m_pc;
  int          m_div;

  task automatic model_reset();
    m_wait  = 0;
    m_flush = 0;
    m_pend  = 0;
    m_pc    = '0;
    m_div   = 0;
  endtask

  task automatic model_advance();
    bit was_flush;
    bit new_flush;
    was_flush = m_flush;
    new_flush = 0;
    if (m_flush) begin
      m_pend = 0;
      m_wait = 0;
    end else if (m_wait) begin
      if (exc_req && !m_pend) begin
        m_pend = 1;
        m_pc   = exc_pc;
      end
      if (mem_data_ok) begin
        m_wait    = 0;
        new_flush = m_pend;
      end
    end else if (exc_req) begin
      m_pc = exc_pc;
      if (!mem_data_req || mem_data_ok) new_flush = 1;
      else begin
        m_wait = 1;
        m_pend = 1;
      end
    end else if (mem_data_req && !mem_data_ok) begin
      m_wait = 1;
    end
    if (was_flush)      m_div = 0;
    else if (m_div > 0) m_div = m_div - 1;
    else if (div_start) m_div = DIV;
    m_flush = new_flush;
  endtask

  // Observed values from the most recent step, for directed spot checks.
  logic [3:0]    obs_stall;
  logic          obs_mws;
  logic          obs_flush;
  logic [PW-1:0] obs_rpc;
  logic          obs_busy;

  // One clock cycle: drive inputs at the falling edge, compare mid-cycle,
  // then let the rising edge advance both the DUT and the model.
  task automatic step(input logic rst_v, input logic ifr, input logic idr,
                      input logic ds, input logic req, input logic ok,
                      input logic exc, input logic [PW-1:0] epc);
    logic [3:0]    e_stall;
    logic          e_mws;
    logic          e_flush;
    logic [PW-1:0] e_rpc;
    logic          hold;
    int            lvl;
    @(negedge clk);
    cpu_rst      = rst_v;
    if_stall_req = ifr;
    id_stall_req = idr;
    div_start    = ds;
    mem_data_req = req;
    mem_data_ok  = ok;
    exc_req      = exc;
    exc_pc       = epc;
    if (rst_v) model_reset();
    #1;
    e_stall = 4'b0000;
    e_mws   = 1'b0;
    e_flush = 1'b0;
    e_rpc   = '0;
    if (!rst_v) begin
      if (m_flush) begin
        e_flush = 1'b1;
        e_rpc   = m_pc;
      end else begin
        hold = exc || (m_wait ? !ok : (req && !ok));
        // Stall depth: number of registers frozen, deepest requester wins.
        lvl = hold ? 4 : (m_div > 0) ? 3 : idr ? 2 : ifr ? 1 : 0;
        e_stall = 4'((1 << lvl) - 1);
        e_mws   = hold;
      end
    end
    check("stall",          64'(stall),          64'(e_stall));
    check("mem_stop_wb",    64'(mem_stop_wb),    64'(e_mws));
    check("flush",          64'(flush),          64'(e_flush));
    check("redirect_valid", 64'(redirect_valid), 64'(e_flush));
    check("redirect_pc",    64'(redirect_pc),    64'(e_rpc));
    check("div_busy",       64'(div_busy),       64'(m_div != 0));
    obs_stall = stall;
    obs_mws   = mem_stop_wb;
    obs_flush = flush;
    obs_rpc   = redirect_pc;
    obs_busy  = div_busy;
    @(posedge clk);
    if (!rst_v) model_advance();
  endtask

  task automatic idle_step();
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0);
  endtask

  initial begin
    logic [3:0] div_exp [6];
    div_exp = '{4'b0000, 4'b0111, 4'b0111, 4'b0111, 4'b0111, 4'b0000};

    cpu_rst = 1'b1; if_stall_req = 1'b0; id_stall_req = 1'b0; div_start = 1'b0;
    mem_data_req = 1'b0; mem_data_ok = 1'b0; exc_req = 1'b0; exc_pc = '0;
    model_reset();

    // Reset state.
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0);
    check("reset_stall", 64'(obs_stall), 64'h0);
    idle_step();

    // IF / ID stalls and same-cycle release.
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0);
    check("plan_if", 64'(obs_stall), 64'b0001);
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0);
    check("plan_id", 64'(obs_stall), 64'b0011);
    idle_step();
    check("plan_release", 64'(obs_stall), 64'b0000);

    // Data wait of 3 cycles, then the response cycle.
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, '0);
      check("plan_dwait_stall", 64'(obs_stall), 64'b1111);
      check("plan_dwait_mws", 64'(obs_mws), 64'h1);
    end
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, '0);
    check("plan_dwait_done", 64'(obs_stall), 64'b0000);
    // Zero-wait access.
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, '0);
    check("plan_zero_wait", 64'(obs_stall), 64'b0000);
    idle_step();

    // Divide: start at t, second start at t+2 is ignored.
    for (int i = 0; i < 6; i++) begin
      step(1'b0, 1'b0, 1'b0, (i == 0 || i == 2), 1'b0, 1'b0, 1'b0, '0);
      check("plan_div", 64'(obs_stall), 64'(div_exp[i]));
    end
    idle_step();

    // Exception in IDLE during a divide.
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, '0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'hBFC0_0380);
    check("plan_exc_hold", 64'(obs_stall), 64'b1111);
    idle_step();
    check("plan_exc_flush", 64'(obs_flush), 64'h1);
    check("plan_exc_pc", 64'(obs_rpc), 64'hBFC0_0380);
    idle_step();
    check("plan_exc_div_clr", 64'(obs_busy), 64'h0);
    check("plan_exc_one_flush", 64'(obs_flush), 64'h0);

    // Deferred exception: first latched PC wins.
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, '0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h8000_0180);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h1234_5678);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, '0);
    check("plan_defer_no_flush", 64'(obs_flush), 64'h0);
    idle_step();
    check("plan_defer_flush", 64'(obs_flush), 64'h1);
    check("plan_defer_pc", 64'(obs_rpc), 64'h8000_0180);
    idle_step();

    // Reset in DMEM_WAIT with an exception parked.
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, '0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'hBFC0_0200);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, '0);
    check("plan_rst_stall", 64'(obs_stall), 64'h0);
    check("plan_rst_mws", 64'(obs_mws), 64'h0);
    for (int i = 0; i < 3; i++) begin
      idle_step();
      check("plan_rst_no_flush", 64'(obs_flush), 64'h0);
    end

    // Randomized traffic.
    for (int i = 0; i < 800; i++) begin
      step(($urandom_range(0, 99) == 0),
           ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 7) == 0),
           ($urandom_range(0, 2) == 0),
           ($urandom_range(0, 2) == 0),
           ($urandom_range(0, 15) == 0),
           $urandom());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
